// File: rtl/input_conditioner.sv
// Conditions one asynchronous, bouncing input: a two-flop synchronizer, then a stability-count
// debouncer, then registered one-cycle rise and fall pulses taken from the debounced level.
module input_conditioner #(
  parameter int counterwidth = 3,
  parameter int waittime     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [counterwidth-1:0] wait_max = counterwidth'(waittime);

  logic                    sync0;
  logic                    sync1;
  logic [counterwidth-1:0] counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      counter      <= '0;
      conditioned  <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      sync0        <= noisysignal;
      sync1        <= sync0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      if (sync1 == conditioned) begin
        counter <= '0;
      end else if (counter != wait_max) begin
        counter <= counter + 1'b1;
      end else begin
        // sync1 has now differed for waittime+1 consecutive edges; take the new level.
        conditioned  <= sync1;
        counter      <= '0;
        positiveedge <= sync1;
        negativeedge <= ~sync1;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized stimulus for input_conditioner, checked against a run-length model of
// the synchronize-then-debounce rules.
module tb_input_conditioner;

  localparam int WT = 3;

  logic clk;
  logic reset;
  logic noisysignal;
  logic conditioned;
  logic positiveedge;
  logic negativeedge;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit hist[$];
  bit m_cond;
  bit m_pe;
  bit m_ne;
  int m_run;

  input_conditioner #(.counterwidth(3), .waittime(WT)) dut (
    .clk(clk),
    .reset(reset),
    .noisysignal(noisysignal),
    .conditioned(conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level seen by the debouncer at an edge is the input sampled two edges earlier.
  task automatic model_edge(input bit r, input bit n);
    bit s1;
    if (r) begin
      hist = '{1'b0, 1'b0};
      m_cond = 0; m_pe = 0; m_ne = 0; m_run = 0;
    end else begin
      s1 = hist[$-1];
      m_pe = 0; m_ne = 0;
      if (s1 != m_cond) begin
        m_run++;
        if (m_run > WT) begin
          m_cond = s1;
          m_pe = s1;
          m_ne = !s1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      hist.push_back(n);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  endtask

  task automatic cyc();
    bit r, n;
    @(posedge clk);
    r = reset;
    n = noisysignal;
    model_edge(r, n);
    #1;
    chk("cond", {7'd0, conditioned}, {7'd0, m_cond});
    chk("posedge", {7'd0, positiveedge}, {7'd0, m_pe});
    chk("negedge", {7'd0, negativeedge}, {7'd0, m_ne});
    chk("counter", {5'd0, dut.counter}, 8'(m_run));
    chk("excl", {7'd0, positiveedge & negativeedge}, 8'd0);
  endtask

  initial begin
    hist = '{1'b0, 1'b0};
    m_cond = 0; m_pe = 0; m_ne = 0; m_run = 0;
    reset = 1'b1;
    noisysignal = 1'b1;
    #1;

    // Reset held for two edges with the input high
    cyc();
    cyc();
    chk("rst_cond", {7'd0, conditioned}, 8'd0);
    chk("rst_cnt", {5'd0, dut.counter}, 8'd0);
    reset = 1'b0;
    noisysignal = 1'b0;
    repeat (3) cyc();

    // Rise: input goes high before edge N; new level shows after edge N+5
    noisysignal = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("rise_cond", {7'd0, conditioned}, (i >= 6) ? 8'd1 : 8'd0);
      chk("rise_pe", {7'd0, positiveedge}, (i == 6) ? 8'd1 : 8'd0);
    end

    // Bounce faster than the acceptance window: level must hold at 1
    fork
      begin
        repeat (23) begin
          #8 noisysignal = ~noisysignal;
        end
      end
      begin
        repeat (10) begin
          cyc();
          chk("bounce_cond", {7'd0, conditioned}, 8'd1);
          chk("bounce_pulse", {6'd0, positiveedge, negativeedge}, 8'd0);
        end
      end
    join
    noisysignal = 1'b1;
    repeat (6) cyc();

    // Fall
    noisysignal = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("fall_cond", {7'd0, conditioned}, (i >= 6) ? 8'd0 : 8'd1);
      chk("fall_ne", {7'd0, negativeedge}, (i == 6) ? 8'd1 : 8'd0);
    end

    // Near-miss: 3-cycle high is rejected
    noisysignal = 1'b1;
    repeat (3) cyc();
    noisysignal = 1'b0;
    repeat (6) begin
      cyc();
      chk("near_cond", {7'd0, conditioned}, 8'd0);
      chk("near_pe", {7'd0, positiveedge}, 8'd0);
    end

    // 4-cycle high is accepted with one rise pulse
    noisysignal = 1'b1;
    repeat (4) cyc();
    noisysignal = 1'b0;
    begin
      int pulses = 0;
      repeat (3) begin
        cyc();
        pulses += int'(positiveedge);
      end
      chk("wide_cond", {7'd0, conditioned}, 8'd1);
      chk("wide_pulses", 8'(pulses), 8'd1);
    end
    repeat (10) cyc();
    chk("wide_back", {7'd0, conditioned}, 8'd0);

    // Reset in the middle of a count
    noisysignal = 1'b1;
    repeat (4) cyc();
    chk("mid_cnt", {5'd0, dut.counter}, 8'd2);
    reset = 1'b1;
    cyc();
    chk("mid_rst_cnt", {5'd0, dut.counter}, 8'd0);
    chk("mid_rst_cond", {7'd0, conditioned}, 8'd0);
    chk("mid_rst_pe", {7'd0, positiveedge}, 8'd0);
    reset = 1'b0;
    noisysignal = 1'b0;
    repeat (6) cyc();

    // Randomized run lengths with occasional resets
    repeat (120) begin
      noisysignal = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 30) == 0);
      repeat ($urandom_range(1, 7)) begin
        cyc();
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
